// File: rtl/instruction_fetch_if.sv
// Bundles the fetch unit's memory handshake and decode-side signals.
// The master modport is the fetch unit; the slave modport is its environment.
interface instruction_fetch_if #(
  parameter int PC_WIDTH    = 16,
  parameter int INSTR_WIDTH = 16
);
  logic                   imem_req;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic                   imem_ack;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic [INSTR_WIDTH-1:0] op;
  logic                   op_valid;
  logic                   stage_ready;
  logic                   branch_taken;
  logic [PC_WIDTH-1:0]    branch_target;
  logic [PC_WIDTH-1:0]    pc_next;
  logic                   halted;
  logic [15:0]            instr_count;

  modport master (
    output imem_req, imem_addr, op, op_valid, pc_next, halted, instr_count,
    input  imem_ack, imem_rdata, stage_ready, branch_taken, branch_target
  );

  modport slave (
    input  imem_req, imem_addr, op, op_valid, pc_next, halted, instr_count,
    output imem_ack, imem_rdata, stage_ready, branch_taken, branch_target
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, fetches from instruction memory with a req/ack
// handshake, holds each word in op until decode consumes it, stops on HLT.
module instruction_fetch_unit #(
  parameter int                 PC_WIDTH    = 16,
  parameter int                 INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = 16'h0000
) (
  input logic                 clk,
  input logic                 rst,
  instruction_fetch_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] op_q, op_d;
  logic [PC_WIDTH-1:0]    pc_next_q, pc_next_d;
  logic                   op_valid_q, op_valid_d;
  logic                   halted_q, halted_d;
  logic [15:0]            instr_count_q, instr_count_d;
  logic                   op_is_hlt;

  assign op_is_hlt = (op_q[15:14] == 2'b11) && (op_q[7:4] == 4'b1111);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      op_q          <= '0;
      pc_next_q     <= '0;
      op_valid_q    <= 1'b0;
      halted_q      <= 1'b0;
      instr_count_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      op_q          <= op_d;
      pc_next_q     <= pc_next_d;
      op_valid_q    <= op_valid_d;
      halted_q      <= halted_d;
      instr_count_q <= instr_count_d;
    end
  end

  // A branch retiring together with HLT still redirects pc before halting.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    op_d          = op_q;
    pc_next_d     = pc_next_q;
    op_valid_d    = op_valid_q;
    halted_d      = halted_q;
    instr_count_d = instr_count_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (bus.imem_ack) begin
          op_d       = bus.imem_rdata;
          pc_d       = pc_q + 1'b1;
          pc_next_d  = pc_q + 1'b1;
          op_valid_d = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (bus.stage_ready) begin
          op_valid_d    = 1'b0;
          instr_count_d = instr_count_q + 16'd1;
          if (bus.branch_taken) begin
            pc_d = bus.branch_target;
          end
          if (op_is_hlt) begin
            state_d  = HALTED;
            halted_d = 1'b1;
          end else begin
            state_d = FETCH;
          end
        end
      end
      HALTED: begin
        op_valid_d = 1'b0;
        halted_d   = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.imem_req    = (state_q == FETCH);
  assign bus.imem_addr   = pc_q;
  assign bus.op          = op_q;
  assign bus.op_valid    = op_valid_q;
  assign bus.pc_next     = pc_next_q;
  assign bus.halted      = halted_q;
  assign bus.instr_count = instr_count_q;

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Upstream fetch stage of the 16-bit processor.
- Owns the program counter and runs a req/ack handshake with instruction memory.
- Latches each fetched word into the instruction register and presents it as op to the decode controllers (data selector controller and siblings).
- Accepts branch redirects from execute and stops fetching on a HLT instruction.

Parameters:
- PC_WIDTH, 16, program counter and imem address width.
- INSTR_WIDTH, 16, instruction word width; op decoding below assumes 16.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  PC_WIDTH  fetch address; equals pc while imem_req=1.
- imem_ack  input  1  memory returns imem_rdata valid this cycle.
- imem_rdata  input  INSTR_WIDTH  fetched instruction word.
- op  output  INSTR_WIDTH  instruction register contents, to decode.
- op_valid  output  1  op holds a live instruction awaiting consumption.
- stage_ready  input  1  downstream consumes op this cycle when op_valid=1.
- branch_taken  input  1  redirect request from execute, qualified with stage_ready.
- branch_target  input  PC_WIDTH  redirect address.
- pc_next  output  PC_WIDTH  address of the instruction after op (pc+1 at capture), for branch/link arithmetic.
- halted  output  1  HLT retired; fetch stopped.
- instr_count  output  16  retired-instruction counter.

Behaviour:
- Reset (async, any state, including mid-handshake):
  - State IDLE; pc=RESET_PC, op=0, pc_next=0, op_valid=0, halted=0, instr_count=0, imem_req=0.
  - Any outstanding memory request is abandoned.
- State flow:
  - IDLE: imem_req=0. Moves to FETCH on the next clock after rst deasserts.
  - FETCH: imem_req=1, imem_addr=pc; both held stable until imem_ack. On imem_ack: op<=imem_rdata, pc_next<=pc+1, pc<=pc+1, op_valid<=1, go to HOLD. Minimum fetch latency is 1 cycle (ack in the first FETCH cycle); the next op is visible the cycle after ack.
  - HOLD: imem_req=0; op and op_valid=1 held stable until stage_ready=1. On stage_ready:
    - op_valid<=0; instr_count<=instr_count+1.
    - If branch_taken: pc<=branch_target.
    - If op is HLT: go to HALTED; otherwise go to FETCH.
  - HALTED: imem_req=0, op_valid=0, halted=1. Exit only by reset.
- HLT decode: op[15:14]==2'b11 and op[7:4]==4'b1111.
- Branch rules:
  - branch_taken is sampled only in HOLD with stage_ready=1; it is ignored in every other state and cycle.
  - If branch_taken and HLT retire together, the branch updates pc and the unit still halts.
- Ignored handshake inputs: imem_ack outside FETCH; stage_ready outside HOLD.
- Arithmetic:
  - pc+1 wraps modulo 2^PC_WIDTH (16'hFFFF -> 16'h0000).
  - instr_count wraps 16'hFFFF -> 16'h0000.
- Throughput: one instruction per 2 cycles at best (FETCH with immediate ack, HOLD with immediate stage_ready).
- Outputs: all registered except imem_req and imem_addr, which are decoded from state and pc.

Test Plan:
- Reset, then ack every request immediately, stage_ready=1, memory holds 16'hC000, 16'hC010 -> imem_addr 0,1,2 on successive FETCH cycles; op_valid pulses one cycle per instruction; instr_count=2 after second retire.
- Ack delayed 3 cycles -> imem_req held 1 and imem_addr constant for 4 cycles; op updates only the cycle after ack.
- Hold stage_ready=0 for 5 cycles in HOLD -> op_valid=1 and op unchanged; no new imem_req; then stage_ready=1 -> next fetch issued.
- Retire 16'hB800 with branch_taken=1, branch_target=16'h0040 -> next imem_addr=16'h0040; pc_next for that op = captured pc+1.
- Fetch 16'hC0F0 (HLT) and consume -> halted=1, imem_req stays 0 for 10+ cycles; assert rst -> halted=0, fetch restarts at RESET_PC.
- pc=16'hFFFF fetch -> next imem_addr=16'h0000; rst asserted mid-FETCH -> imem_req drops immediately (async), op_valid=0.
